blob_bbox: RTL

BLOB_BBOX -- requirements
Module: blob_bbox

---
 rtl/blob_pkg.sv | 22 ++
 rtl/blob_raster_counter.sv | 53 +++++
 rtl/blob_bbox.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/blob_pkg.sv
// Shared types and default geometry for the blob bounding-box tracker.
package blob_pkg;

  typedef logic [7:0]  coord_t;
  typedef logic [15:0] count_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam int DEF_IMG_W      = 160;
  localparam int DEF_IMG_H      = 120;
  localparam int DEF_MIN_PIXELS = 16;
  localparam int DEF_RUN_LEN    = 3;

  localparam coord_t COORD_MIN_INIT = 8'hFF;
  localparam coord_t COORD_MAX_INIT = 8'h00;
  localparam count_t COUNT_SAT      = 16'hFFFF;

endpackage

// File: rtl/blob_raster_counter.sv
// Raster x/y position tracker; clear restarts at (0,0) in the same cycle so a
// pixel arriving alongside the frame start is treated as the first pixel.
module blob_raster_counter
  import blob_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   advance,
  output coord_t x,
  output coord_t y,
  output logic   last
);

  localparam coord_t X_LAST = coord_t'(IMG_W - 1);
  localparam coord_t Y_LAST = coord_t'(IMG_H - 1);

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   line_end;

  assign x        = clear ? '0 : x_q;
  assign y        = clear ? '0 : y_q;
  assign line_end = (x == X_LAST);
  assign last     = line_end && (y == Y_LAST);

  always_comb begin
    x_d = x;
    y_d = y;
    if (advance) begin
      if (line_end) begin
        x_d = '0;
        y_d = last ? '0 : y + 8'd1;
      end else begin
        x_d = x + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/blob_bbox.sv
// Per-frame bounding box and pixel count of motion pixels.
// Define BLOB_RUN_FILTER_EN to qualify only pixels inside horizontal runs of RUN_LEN or more.
module blob_bbox
  import blob_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int MIN_PIXELS = DEF_MIN_PIXELS,
  parameter int RUN_LEN    = DEF_RUN_LEN
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iFrameStart,
  input  logic        iPixelValid,
  input  logic        iMotion,
  output logic [7:0]  oXmin,
  output logic [7:0]  oXmax,
  output logic [7:0]  oYmin,
  output logic [7:0]  oYmax,
  output logic        oNewCoord,
  output logic        oFrameDone,
  output logic [15:0] oPixelCount
);

  localparam count_t MIN_C = count_t'(MIN_PIXELS);

  if (IMG_W < 2 || IMG_W > 256 || IMG_H < 2 || IMG_H > 256 || RUN_LEN < 1) begin : g_cfg_check
    $error("blob_bbox: parameter out of range");
  end

  state_t state_q, state_d;
  logic   done_q, done_d;
  coord_t rxmin_q, rxmin_d, rxmax_q, rxmax_d, rymin_q, rymin_d, rymax_q, rymax_d;
  count_t cnt_q, cnt_d;
  coord_t xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic   new_q, new_d, fdone_q, fdone_d;
  count_t pcnt_q, pcnt_d;

  logic   accept, qualify, last_px;
  coord_t px_x, px_y, xmin_cand;
  coord_t rxmin_b, rxmax_b, rymin_b, rymax_b;
  count_t cnt_b;

  // done_q marks the cycle after the final pixel; it blocks further
  // acceptance and gives the extra pipeline stage before publishing.
  assign accept = iPixelValid && (iFrameStart || (state_q == SCAN && !done_q));

  blob_raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_raster (
    .clk     (iClock),
    .rst_n   (iReset),
    .clear   (iFrameStart),
    .advance (accept),
    .x       (px_x),
    .y       (px_y),
    .last    (last_px)
  );

`ifdef BLOB_RUN_FILTER_EN
  localparam count_t RUN_C = count_t'(RUN_LEN);
  count_t run_q, run_d, run_b, run_inc;
  logic   line_end;

  assign line_end = (px_x == coord_t'(IMG_W - 1));
  assign run_b    = iFrameStart ? '0 : run_q;
  assign run_inc  = (run_b >= RUN_C) ? RUN_C : run_b + 16'd1;

  always_comb begin
    run_d     = run_b;
    qualify   = 1'b0;
    xmin_cand = px_x;
    if (accept) begin
      if (iMotion) begin
        qualify = (run_inc == RUN_C);
        // The first qualifying pixel of a run pulls in the run's start.
        if (run_b == RUN_C - 16'd1)
          xmin_cand = px_x - coord_t'(RUN_LEN - 1);
        run_d = line_end ? '0 : run_inc;
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) run_q <= '0;
    else         run_q <= run_d;
  end
`else
  assign qualify   = accept && iMotion;
  assign xmin_cand = px_x;
`endif

  always_comb begin
    rxmin_b = iFrameStart ? COORD_MIN_INIT : rxmin_q;
    rxmax_b = iFrameStart ? COORD_MAX_INIT : rxmax_q;
    rymin_b = iFrameStart ? COORD_MIN_INIT : rymin_q;
    rymax_b = iFrameStart ? COORD_MAX_INIT : rymax_q;
    cnt_b   = iFrameStart ? '0 : cnt_q;

    rxmin_d = rxmin_b;
    rxmax_d = rxmax_b;
    rymin_d = rymin_b;
    rymax_d = rymax_b;
    cnt_d   = cnt_b;
    if (qualify) begin
      if (xmin_cand < rxmin_b) rxmin_d = xmin_cand;
      if (px_x > rxmax_b)      rxmax_d = px_x;
      if (px_y < rymin_b)      rymin_d = px_y;
      if (px_y > rymax_b)      rymax_d = px_y;
      cnt_d = (cnt_b == COUNT_SAT) ? COUNT_SAT : cnt_b + 16'd1;
    end

    done_d  = accept && last_px;
    state_d = state_q;
    case (state_q)
      SCAN:    if (done_q) state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (iFrameStart) state_d = SCAN;

    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    new_d   = new_q;
    pcnt_d  = pcnt_q;
    fdone_d = (state_q == PUBLISH);
    if (state_q == PUBLISH) begin
      pcnt_d = cnt_q;
      // A zero count never publishes, keeping the min <= max invariant.
      if (cnt_q >= MIN_C && cnt_q != '0) begin
        xmin_d = rxmin_q;
        xmax_d = rxmax_q;
        ymin_d = rymin_q;
        ymax_d = rymax_q;
        new_d  = 1'b1;
      end else begin
        new_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      rxmin_q <= COORD_MIN_INIT;
      rxmax_q <= COORD_MAX_INIT;
      rymin_q <= COORD_MIN_INIT;
      rymax_q <= COORD_MAX_INIT;
      cnt_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      new_q   <= 1'b0;
      fdone_q <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      rxmin_q <= rxmin_d;
      rxmax_q <= rxmax_d;
      rymin_q <= rymin_d;
      rymax_q <= rymax_d;
      cnt_q   <= cnt_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      new_q   <= new_d;
      fdone_q <= fdone_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign oXmin       = xmin_q;
  assign oXmax       = xmax_q;
  assign oYmin       = ymin_q;
  assign oYmax       = ymax_q;
  assign oNewCoord   = new_q;
  assign oFrameDone  = fdone_q;
  assign oPixelCount = pcnt_q;

endmodule
